seven_segment_scan_controller: RTL and testbench
================================================

// Module: seven_segment_scan_controller
// PURPOSE
//   Time-multiplexes one combinational seven-segment decoder across NUM_DIGITS
//   common-select digits. Scans digit indices, drives the decoder's 4-bit input,
//   gates the decoded segments to the shared segment bus and asserts one digit
//   enable at a time, with blanking guard slots and optional leading-zero blanking.
//   Sits between the value producer (counters/registers) and the board display pins.
// PARAMETERS
//   NUM_DIGITS    4     digits scanned, >=2
//   REFRESH_DIV   1000  clk cycles a digit is lit per slot, >=1
//   BLANK_CYCLES  2     all-off cycles before each digit (anti-ghosting), >=1
// PORTS
//   clk          in   1              system clock, rising edge
//   rst          in   1              synchronous reset, active-high
//   Value_in     in   4*NUM_DIGITS   packed nibbles; digit k = Value_in[4k+3:4k], k=0 is LSD
//   Load         in   1              1-cycle strobe: capture Value_in into shadow register
//   Enable       in   1              1 = scan, 0 = display dark
//   Lz_suppress  in   1              1 = blank leading zero digits (digit 0 never blanked)
//   Binary_out   out  4              nibble to decoder Binary_in
//   Seg_in       in   7              decoder Seg output (combinational return)
//   Seg_out      out  7              segment bus to pins, active-high
//   Digit_en     out  NUM_DIGITS     one-hot digit select, active-high
//   Frame_done   out  1              1-cycle pulse at end of each full scan frame
// BEHAVIOUR
//   - Reset: shadow=0, display reg=0, idx=0, slot counter=0, state=IDLE,
//     Binary_out=0, Seg_out=0, Digit_en=0, Frame_done=0. Applies on next clk edge
//     from any state, including mid-slot; pending Load is discarded.
//   - Registers: shadow (written on Load), display (frame-stable copy used for scan).
//   - FSM: IDLE -> BLANK -> SHOW -> BLANK ... ; Enable=0 in any state -> IDLE next
//     cycle with Digit_en=0, Seg_out=0; counter and idx cleared.
//     IDLE: outputs dark; Enable=1 -> BLANK, idx=0, display<=shadow (or Value_in if Load same cycle).
//     BLANK: Digit_en=0, Seg_out=0, Binary_out=display nibble[idx] (decoder settles);
//       after BLANK_CYCLES cycles -> SHOW.
//     SHOW: Digit_en=onehot(idx) unless suppressed, Seg_out=Seg_in when digit lit else 0;
//       after REFRESH_DIV cycles -> BLANK with idx+1; idx wraps NUM_DIGITS-1 -> 0.
//   - Slot length = BLANK_CYCLES+REFRESH_DIV; frame = NUM_DIGITS * slot length.
//   - Frame_done=1 on the last SHOW cycle of idx=NUM_DIGITS-1; at that edge
//     display<=shadow. Load in that same cycle: Value_in wins and is shown next frame.
//     Load at any other time: visible from next frame start only (no tearing).
//   - Leading-zero: with Lz_suppress=1, digit k>0 is dark (Digit_en bit 0, Seg_out=0)
//     when display nibbles k..NUM_DIGITS-1 are all 0; slot timing unchanged.
//     Lz_suppress sampled every cycle (takes effect immediately).
//   - Binary_out constant through BLANK+SHOW of a slot; changes only on BLANK entry.
//   - Digit_en never has more than one bit set; never set during BLANK.
//   - Counters sized $clog2 of their limit; no overflow beyond limit.
// TESTING (bench params NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1)
//   1 rst, Load Value_in=16'h1234, Enable=1 -> 2nd frame shows idx0..3 Binary_out
//     4,3,2,1; Digit_en 0001,0010,0100,1000 for 4 cycles each, 1-cycle dark gaps;
//     Frame_done every 20 cycles.
//   2 Load 16'h00A7 mid-frame -> current frame finishes old value; next frame A7;
//     Load 16'h5555 on Frame_done cycle -> next frame shows 5555.
//   3 Value 16'h0007, Lz_suppress=1 -> only Digit_en=0001 lit, Seg_out=0 in slots 1-3;
//     value 16'h0000 -> digit 0 still lit with Seg_in of '0'.
//   4 Enable dropped mid-SHOW -> next cycle Digit_en=0, Seg_out=0; re-enable
//     restarts at idx0 with BLANK.
//   5 rst asserted mid-SHOW of idx2 -> next edge all outputs 0, state IDLE.
//   6 Every cycle: assert onehot0(Digit_en) and Seg_out==0 whenever Digit_en==0.

Source files
------------

// File: rtl/seven_segment_scan_controller.sv
// Seven-segment scan controller: time-multiplexes one external decoder across
// NUM_DIGITS digits. Each slot is a dark guard period followed by a lit period,
// and an optional leading-zero blank. New values are taken only at frame start.
module seven_segment_scan_controller #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] Value_in,
  input  logic                    Load,
  input  logic                    Enable,
  input  logic                    Lz_suppress,
  output logic [3:0]              Binary_out,
  input  logic [6:0]              Seg_in,
  output logic [6:0]              Seg_out,
  output logic [NUM_DIGITS-1:0]   Digit_en,
  output logic                    Frame_done
);

  localparam int unsigned CntLim = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CntW   = (CntLim > 1) ? $clog2(CntLim) : 1;
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [IdxW-1:0]         idx_q;
  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic [4*NUM_DIGITS-1:0] display_q;
  logic [4*NUM_DIGITS-1:0] next_frame;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic                    lz_dark;
  logic                    lit;

  // A Load coinciding with a frame boundary wins over the older shadow copy.
  assign next_frame = Load ? Value_in : shadow_q;

  // Scan FSM, slot counter, digit index, shadow/display registers and decoder input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      display_q  <= '0;
      Binary_out <= '0;
    end else begin
      if (Load) shadow_q <= Value_in;
      if (!Enable) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        idx_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q    <= StBlank;
            cnt_q      <= '0;
            idx_q      <= '0;
            display_q  <= next_frame;
            Binary_out <= next_frame[3:0];
          end
          StBlank: begin
            if (cnt_q == BlankLast) begin
              state_q <= StShow;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StShow: begin
            if (cnt_q == ShowLast) begin
              state_q <= StBlank;
              cnt_q   <= '0;
              if (idx_q == IdxLast) begin
                idx_q      <= '0;
                display_q  <= next_frame;
                Binary_out <= next_frame[3:0];
              end else begin
                idx_q      <= idx_q + 1'b1;
                Binary_out <= display_q[4*(int'(idx_q) + 1) +: 4];
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // upper_zero[k]: display nibbles k..NUM_DIGITS-1 are all zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (display_q[4*NUM_DIGITS-1 -: 4] == 4'h0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      upper_zero[k] = upper_zero[k+1] & (display_q[4*k +: 4] == 4'h0);
    end
  end

  // Digit select and segment gating; Lz_suppress acts in the same cycle.
  always_comb begin
    lz_dark    = Lz_suppress && (idx_q != '0) && upper_zero[idx_q];
    lit        = (state_q == StShow) && !lz_dark;
    Digit_en   = lit ? (NUM_DIGITS'(1) << idx_q) : '0;
    Seg_out    = lit ? Seg_in : 7'h00;
    Frame_done = (state_q == StShow) && (cnt_q == ShowLast) && (idx_q == IdxLast);
  end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for seven_segment_scan_controller: directed scenarios plus random
// stimulus, checked every cycle against a frame-position reference model.
module tb_seven_segment_scan_controller;

  localparam int unsigned N  = 4;
  localparam int unsigned R  = 4;
  localparam int unsigned B  = 1;
  localparam int unsigned S  = B + R;
  localparam int unsigned F  = N * S;

  logic          clk = 1'b0;
  logic          rst, load, enable, lz;
  logic [15:0]   value;
  logic [3:0]    binary_out;
  logic [6:0]    seg_in, seg_out;
  logic [N-1:0]  digit_en;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  // Reference model state: running flag, position within frame, registers.
  bit            m_run;
  int            m_pos;
  logic [15:0]   m_disp, m_shadow;
  logic [3:0]    m_bin;

  seven_segment_scan_controller #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Value_in   (value),
    .Load       (load),
    .Enable     (enable),
    .Lz_suppress(lz),
    .Binary_out (binary_out),
    .Seg_in     (seg_in),
    .Seg_out    (seg_out),
    .Digit_en   (digit_en),
    .Frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                           7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};
    return t[v];
  endfunction

  // External decoder stand-in.
  assign seg_in = seg7(binary_out);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int slot, off;
    bit show, dark;
    logic [N-1:0] e_en;
    logic [6:0]   e_seg;
    e_en  = '0;
    e_seg = '0;
    if (m_run) begin
      slot = m_pos / S;
      off  = m_pos % S;
      show = (off >= B);
      dark = lz && slot > 0 && ((m_disp >> (4 * slot)) == 16'h0);
      if (show && !dark) begin
        e_en  = N'(1 << slot);
        e_seg = seg7(m_bin);
      end
    end
    check_eq("binary_out", 32'(binary_out), 32'(m_bin));
    check_eq("digit_en", 32'(digit_en), 32'(e_en));
    check_eq("seg_out", 32'(seg_out), 32'(e_seg));
    check_eq("frame_done", 32'(frame_done), 32'(m_run && m_pos == F - 1));
    check_eq("onehot0", 32'($onehot0(digit_en)), 32'd1);
    if (digit_en == '0) check_eq("dark_segs", 32'(seg_out), 32'd0);
  endtask

  function automatic logic [3:0] nib(input logic [15:0] v, input int k);
    return 4'((v >> (4 * k)) & 16'hf);
  endfunction

  task automatic model_step();
    logic [15:0] nf;
    nf = load ? value : m_shadow;
    if (rst) begin
      m_run = 0; m_pos = 0; m_shadow = '0; m_disp = '0; m_bin = '0;
      return;
    end
    if (!enable) begin
      m_run = 0; m_pos = 0;
    end else if (!m_run) begin
      m_run = 1; m_pos = 0; m_disp = nf; m_bin = nib(nf, 0);
    end else if (m_pos == F - 1) begin
      m_pos = 0; m_disp = nf; m_bin = nib(nf, 0);
    end else begin
      m_pos++;
      if (m_pos % S == 0) m_bin = nib(m_disp, m_pos / S);
    end
    m_shadow = nf;
  endtask

  task automatic cycle(input logic r, input logic en, input logic ld,
                       input logic [15:0] v, input logic l);
    @(negedge clk);
    rst = r; enable = en; load = ld; value = v; lz = l;
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
  endtask

  initial begin
    logic [15:0] rv;
    rst = 1; enable = 0; load = 0; value = '0; lz = 0;
    m_run = 0; m_pos = 0; m_shadow = '0; m_disp = '0; m_bin = '0;
    @(posedge clk);
    cycle(1, 0, 0, 16'h0, 0);
    @(negedge clk); #1;
    check_eq("rst_digit_en", 32'(digit_en), 32'd0);
    check_eq("rst_binary", 32'(binary_out), 32'd0);

    // Load 1234 and scan two-plus frames.
    cycle(0, 0, 1, 16'h1234, 0);
    for (int i = 0; i < 2 * F + 3; i++) cycle(0, 1, 0, 16'hffff, 0);
    // Mid-frame load, then a load on the frame_done cycle.
    cycle(0, 1, 1, 16'h00a7, 0);
    for (int i = 0; i < F + 2; i++) cycle(0, 1, 0, 16'h0, 0);
    for (int i = 0; i < F && !(m_run && m_pos == F - 1); i++) cycle(0, 1, 0, 16'h0, 0);
    check_eq("fd_reached", 32'(m_run && m_pos == F - 1), 32'd1);
    cycle(0, 1, 1, 16'h5555, 0);
    for (int i = 0; i < F; i++) cycle(0, 1, 0, 16'h0, 0);
    // Leading-zero blanking, then all-zero value.
    cycle(0, 1, 1, 16'h0007, 1);
    for (int i = 0; i < 2 * F; i++) cycle(0, 1, 0, 16'h0, 1);
    cycle(0, 1, 1, 16'h0000, 1);
    for (int i = 0; i < 2 * F; i++) cycle(0, 1, 0, 16'h0, 1);
    // Drop Enable during SHOW, then re-enable.
    cycle(0, 1, 1, 16'h9876, 0);
    for (int i = 0; i < F && !(m_run && m_pos % S == B + 1); i++) cycle(0, 1, 0, 16'h0, 0);
    cycle(0, 0, 0, 16'h0, 0);
    @(negedge clk); #1;
    check_eq("en_drop_dark", 32'(digit_en), 32'd0);
    for (int i = 0; i < F + 3; i++) cycle(0, 1, 0, 16'h0, 0);
    // Reset during SHOW of digit 2.
    for (int i = 0; i < F && !(m_run && m_pos == 2 * S + B + 1); i++) cycle(0, 1, 0, 16'h0, 0);
    check_eq("idx2_reached", 32'(digit_en), 32'b0100);
    cycle(1, 1, 1, 16'hbeef, 0);
    @(negedge clk); #1;
    check_eq("rst_mid_en", 32'(digit_en), 32'd0);
    check_eq("rst_mid_seg", 32'(seg_out), 32'd0);
    check_eq("rst_mid_bin", 32'(binary_out), 32'd0);
    check_eq("rst_mid_fd", 32'(frame_done), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rv = '0;
      for (int k = 0; k < 4; k++)
        if ($urandom_range(1, 0) == 1) rv[4*k +: 4] = 4'($urandom_range(15, 0));
      cycle($urandom_range(199, 0) == 0, $urandom_range(39, 0) != 0,
            $urandom_range(9, 0) == 0, rv, $urandom_range(3, 0) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
